// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two requesters shared access to a single-port data memory
// Each access takes three cycles (IDLE grant, ACCESS strobe, RESP response); misaligned requests are rejected in IDLE.
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic              err_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic              err_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, owner_q, owner_d, ready_q;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_wdata;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic sel, sel_we, take, mis, go;
  always_comb begin
    sel = (req_0 & req_1) ? ptr_q : req_1;
    sel_we = sel ? we_1 : we_0;
    sel_addr = sel ? addr_1 : addr_0;
    sel_wdata = sel ? wdata_1 : wdata_0;
    // ready_q holds off grants until the first clock edge after reset release
    take = ready_q & (state_q == IDLE) & (req_0 | req_1);
    mis = take & (sel_addr[1:0] != 2'b00);
    go = take & ~mis;
    state_d = go ? ACCESS : (state_q == ACCESS) ? RESP : IDLE;
    ptr_d = take ? ~sel : ptr_q;
    owner_d = go ? sel : owner_q;
    mem_read_d = go & ~sel_we;
    mem_write_d = go & sel_we;
    addr_d = go ? sel_addr : addr_q;
    wdata_d = go ? sel_wdata : wdata_q;
    rdata0_d = (mem_read_q & ~owner_q) ? read_data : rdata0_q;
    rdata1_d = (mem_read_q & owner_q) ? read_data : rdata1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      ready_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      ready_q <= 1'b1;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign gnt_0 = take & ~sel;
  assign gnt_1 = take & sel;
  assign err_0 = mis & ~sel;
  assign err_1 = mis & sel;
  assign rvalid_0 = (state_q == RESP) & ~owner_q;
  assign rvalid_1 = (state_q == RESP) & owner_q;
  assign rdata_0 = rdata0_q;
  assign rdata_1 = rdata1_q;
  assign MemRead = mem_read_q;
  assign MemWrite = mem_write_q;
  assign addr = addr_q;
  assign write_data = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, multi-cycle corner sequences and a randomized run against a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  logic clk = 0, rst_n = 0, load_ram = 0;
  logic req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic gnt_0, rvalid_0, err_0, gnt_1, rvalid_1, err_1, MemRead, MemWrite;
  logic [DW-1:0] rdata_0, rdata_1, write_data, read_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] ram [128];
  int pass_n = 0, total_n = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .err_0(err_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .err_1(err_1), .rdata_1(rdata_1),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // memory model: asynchronous read, synchronous write
  assign read_data = ram[addr[AW-1:2]];
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 128; i++) ram[i] <= {16'hD00D, 16'(i)};
    end else if (MemWrite) ram[addr[AW-1:2]] <= write_data;
  end

  function automatic logic [7:0] flags();
    return {gnt_0, gnt_1, err_0, err_1, rvalid_0, rvalid_1, MemRead, MemWrite};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
    req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    load_ram = 1;
    @(negedge clk);
    load_ram = 0;
    check("rst_flags", flags(), 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_rdata", {rdata_0, rdata_1}, 0);
    rst_n = 1;
    #1 check("rel_no_gnt", {gnt_0, gnt_1}, 0);
  endtask

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [7:0] f; logic [AW-1:0] ea; logic [DW-1:0] rd0, rd1;
  } vec_t;
  vec_t v[14];

  // transaction-level reference model state
  int ptr, phase, po, win;
  logic pw, mis;
  logic [AW-1:0] pa, la, sa;
  logic [DW-1:0] pd, ld, sd;
  logic [DW-1:0] rdm [2];
  logic [DW-1:0] refm [128];
  logic [7:0] e;

  initial begin
    logic [AW-1:0] ra0, ra1;
    int g_cyc[$], g_who[$];
    // flags = {gnt0,gnt1,err0,err1,rv0,rv1,MemRead,MemWrite}
    v[0]  = '{1,1,9'h010,32'hCAFE0001, 0,0,0,0, 8'h80, 9'h000, 0, 0};
    v[1]  = '{0,0,0,0, 0,0,0,0, 8'h01, 9'h010, 0, 0};
    v[2]  = '{0,0,0,0, 0,0,0,0, 8'h08, 9'h010, 0, 0};
    v[3]  = '{0,0,0,0, 1,0,9'h010,0, 8'h40, 9'h010, 0, 0};
    v[4]  = '{0,0,0,0, 0,0,0,0, 8'h02, 9'h010, 0, 0};
    v[5]  = '{0,0,0,0, 0,0,0,0, 8'h04, 9'h010, 0, 32'hCAFE0001};
    v[6]  = '{1,0,9'h013,0, 0,0,0,0, 8'hA0, 9'h010, 0, 32'hCAFE0001};
    v[7]  = '{1,0,9'h010,0, 0,0,0,0, 8'h80, 9'h010, 0, 32'hCAFE0001};
    v[8]  = '{0,0,0,0, 1,0,9'h014,0, 8'h02, 9'h010, 0, 32'hCAFE0001};
    v[9]  = '{0,0,0,0, 1,0,9'h014,0, 8'h08, 9'h010, 32'hCAFE0001, 32'hCAFE0001};
    v[10] = '{0,0,0,0, 1,0,9'h014,0, 8'h40, 9'h010, 32'hCAFE0001, 32'hCAFE0001};
    v[11] = '{0,0,0,0, 0,0,0,0, 8'h02, 9'h014, 32'hCAFE0001, 32'hCAFE0001};
    v[12] = '{0,0,0,0, 0,0,0,0, 8'h04, 9'h014, 32'hCAFE0001, 32'hD00D0005};
    v[13] = '{0,0,0,0, 0,0,0,0, 8'h00, 9'h014, 32'hCAFE0001, 32'hD00D0005};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
      #2;
      check($sformatf("vec%0d_flags", i), flags(), v[i].f);
      check($sformatf("vec%0d_addr", i), addr, v[i].ea);
      check($sformatf("vec%0d_rdata0", i), rdata_0, v[i].rd0);
      check($sformatf("vec%0d_rdata1", i), rdata_1, v[i].rd1);
    end

    // reset in the middle of a store access
    @(negedge clk);
    drive(1, 1, 9'h020, 32'h00001234, 0, 0, 0, 0);
    #2 check("mid_gnt", flags(), 8'h80);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("mid_strobe", flags(), 8'h01);
    rst_n = 0;
    #1 check("mid_rst_flags", flags(), 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_rdata1", rdata_1, 0);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2 check("mid_quiet", flags(), 0);
    end
    @(negedge clk);
    drive(1, 1, 9'h024, 32'h11, 1, 1, 9'h028, 32'h22);
    #2 check("mid_ptr0", flags(), 8'h80);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // contention from reset: grants alternate every third cycle
    drive(1, 1, 9'h030, 32'hA0, 1, 1, 9'h034, 32'hB0);
    do_reset();
    for (int c = 0; c < 20 && g_cyc.size() < 4; c++) begin
      @(negedge clk);
      #2;
      if (gnt_0 & gnt_1 || MemRead & MemWrite || rvalid_0 & rvalid_1 || err_0 & err_1)
        check("cont_exclusive", flags(), 0);
      if (gnt_0 | gnt_1) begin
        g_cyc.push_back(c);
        g_who.push_back(gnt_1 ? 1 : 0);
      end
    end
    check("cont_count", g_cyc.size(), 4);
    for (int n = 0; n < g_cyc.size(); n++) begin
      check($sformatf("cont_cyc%0d", n), g_cyc[n], 3 * n);
      check($sformatf("cont_who%0d", n), g_who[n], n % 2);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic against the transaction-level model
    do_reset();
    ptr = 0; phase = 0; po = 0; pw = 0; pa = '0; pd = '0; la = '0; ld = '0;
    rdm[0] = '0; rdm[1] = '0;
    for (int i = 0; i < 128; i++) refm[i] = {16'hD00D, 16'(i)};
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      ra0 = AW'($urandom);
      ra1 = AW'($urandom);
      if ($urandom_range(0, 3) != 0) ra0[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) ra1[1:0] = 2'b00;
      drive(1'($urandom), 1'($urandom), ra0, $urandom, 1'($urandom), 1'($urandom), ra1, $urandom);
      #2;
      e = 0; win = -1; mis = 0;
      if (phase == 0 && (req_0 || req_1)) begin
        win = (req_0 && req_1) ? ptr : (req_1 ? 1 : 0);
        sa = win ? addr_1 : addr_0;
        sd = win ? wdata_1 : wdata_0;
        mis = sa[1:0] != 2'b00;
        e[7 - win] = 1;
        if (mis) e[5 - win] = 1;
      end
      if (phase == 1) e[pw ? 0 : 1] = 1;
      if (phase == 2) e[3 - po] = 1;
      check("rnd_flags", flags(), e);
      check("rnd_addr", addr, la);
      check("rnd_wdata", write_data, ld);
      check("rnd_rdata", {rdata_0, rdata_1}, {rdm[0], rdm[1]});
      if (phase == 1) begin
        if (pw) refm[pa[AW-1:2]] = pd;
        else rdm[po] = refm[pa[AW-1:2]];
        phase = 2;
      end else if (phase == 2) phase = 0;
      else if (win >= 0) begin
        ptr = 1 - win;
        if (!mis) begin
          phase = 1; po = win; pw = win ? we_1 : we_0; pa = sa; pd = sd; la = sa; ld = sd;
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
